branch_history_indexer: RTL and testbench
=========================================

BRANCH_HISTORY_INDEXER -- requirements
Module: branch_history_indexer

Interface
REQ-001 Parameter INDEX_LEN, default 8, SHALL set table index width and global history (GHR) width.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two, SHALL set in-flight branch record capacity.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be asynchronous, active-high reset.
REQ-005 IN_pcValid  input  1  fetch presents a conditional branch this cycle.
REQ-006 IN_pc  input  32  branch PC.
REQ-007 IN_predTaken  input  1  counter MSB returned by the prediction table for OUT_readAddr, same cycle.
REQ-008 OUT_readAddr  output  INDEX_LEN  table read index.
REQ-009 OUT_stall  output  1  record FIFO full; fetch SHALL hold the branch.
REQ-010 IN_resolveValid  input  1  oldest in-flight branch resolved this cycle.
REQ-011 IN_resolveTaken  input  1  actual direction.
REQ-012 IN_mispredict  input  1  resolved direction differs from prediction.
REQ-013 IN_flush  input  1  external pipeline flush (exception/redirect).
REQ-014 OUT_writeEn / OUT_writeAddr (INDEX_LEN) / OUT_writeTaken  outputs  table update port.

Function
REQ-015 OUT_readAddr SHALL equal IN_pc[INDEX_LEN+1:2] XOR specGHR, combinational, zero latency.
REQ-016 OUT_stall SHALL equal (count == FIFO_DEPTH), combinational from registered count.
REQ-017 Push: IN_pcValid && !OUT_stall SHALL write record {index=OUT_readAddr, hist=specGHR} at tail and SHALL set specGHR <= {specGHR[INDEX_LEN-2:0], IN_predTaken}.
REQ-018 IN_pcValid while OUT_stall SHALL be ignored (no push, no GHR change).
REQ-019 Resolve: IN_resolveValid && count != 0 SHALL pop the head record; resolve when empty SHALL be ignored.
REQ-020 On valid resolve, next cycle OUT_writeEn=1, OUT_writeAddr=head.index, OUT_writeTaken=IN_resolveTaken (1-cycle registered latency); otherwise OUT_writeEn=0.
REQ-021 On valid resolve, commitGHR SHALL shift in IN_resolveTaken.
REQ-022 Valid resolve with IN_mispredict SHALL set specGHR <= {head.hist[INDEX_LEN-2:0], IN_resolveTaken} and empty the FIFO (count=0, head=tail).
REQ-023 IN_mispredict without IN_resolveValid SHALL be ignored.
REQ-024 IN_flush SHALL set specGHR <= commitGHR (including same-cycle resolve shift) and empty the FIFO; table update from a same-cycle resolve SHALL still be emitted.
REQ-025 Priority: flush > mispredict recovery > push; a push in a recovery/flush cycle SHALL be dropped.
REQ-026 Simultaneous push and non-mispredict pop SHALL leave count unchanged; pop when full plus push SHALL be allowed only if OUT_stall was low (i.e. no push when full, regardless of pop).
REQ-027 Pointers SHALL be log2(FIFO_DEPTH) bits wrapping modulo FIFO_DEPTH; count log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 rst SHALL asynchronously clear specGHR, commitGHR, pointers, count to 0 and OUT_writeEn, OUT_writeAddr, OUT_writeTaken to 0; OUT_stall=0 after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight records with no table update emitted.
REQ-030 Record storage contents need not be reset.

Structure
REQ-031 INDEX_LEN default, FIFO_DEPTH default and the record struct {index, hist} SHALL live in the shared core package.
REQ-032 The record FIFO SHALL be a sub-module BranchRecordFifo (push, pop, clear, full, empty, head data); GHR logic stays in the top.

Verification
REQ-033 Reset, pc=0x100, specGHR=0 -> OUT_readAddr=0x40; predTaken=1 push -> specGHR=0x01, next readAddr for pc=0x100 = 0x41.
REQ-034 Eight pushes with no resolve -> OUT_stall=1; ninth IN_pcValid ignored, GHR unchanged; one resolve -> OUT_stall=0 next cycle.
REQ-035 Push A (idx 0x40), resolve taken, no mispredict -> one cycle later OUT_writeEn=1, addr=0x40, taken=1; commitGHR=0x01.
REQ-036 Three pushes predicted taken (specGHR=0x07), resolve first with mispredict, taken=0 -> specGHR=0x00, count=0, update addr=first index, taken=0.
REQ-037 Flush with commitGHR=0x05 and four records in flight -> specGHR=0x05, count=0, OUT_stall=0; same-cycle push dropped.
REQ-038 rst asserted asynchronously between clock edges with records in flight -> outputs zero immediately, no OUT_writeEn pulse after release.

Source files
------------

// File: rtl/branch_history_indexer_pkg.sv
// Shared core package for the branch history indexer: default sizes and the
// in-flight branch record layout.
package branch_history_indexer_pkg;

    localparam int BHI_INDEX_LEN  = 8;
    localparam int BHI_FIFO_DEPTH = 8;

    // One in-flight branch: table index used for the prediction and the
    // speculative history it was predicted with (for misprediction recovery).
    typedef struct packed {
        logic [BHI_INDEX_LEN-1:0] index;
        logic [BHI_INDEX_LEN-1:0] hist;
    } bhi_rec_t;

    localparam int BHI_REC_W = $bits(bhi_rec_t);

endpackage

// File: rtl/branch_history_indexer_fifo.sv
// In-order record FIFO for in-flight branches. Clear empties it in one cycle
// and takes priority over push/pop; storage itself is never reset.
module BranchRecordFifo
    import branch_history_indexer_pkg::*;
#(
    parameter int W     = BHI_REC_W,
    parameter int DEPTH = BHI_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW:0]   count;
    logic [W-1:0]  mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[head_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PW'(1);
            if (do_pop)  head_ptr <= head_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[tail_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_history_indexer.sv
// Gshare-style index generator with speculative/committed global history,
// in-flight record tracking, and misprediction/flush history recovery.
module branch_history_indexer
    import branch_history_indexer_pkg::*;
#(
    parameter int INDEX_LEN  = BHI_INDEX_LEN,
    parameter int FIFO_DEPTH = BHI_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IN_pcValid,
    input  logic [31:0]          IN_pc,
    input  logic                 IN_predTaken,
    output logic [INDEX_LEN-1:0] OUT_readAddr,
    output logic                 OUT_stall,
    input  logic                 IN_resolveValid,
    input  logic                 IN_resolveTaken,
    input  logic                 IN_mispredict,
    input  logic                 IN_flush,
    output logic                 OUT_writeEn,
    output logic [INDEX_LEN-1:0] OUT_writeAddr,
    output logic                 OUT_writeTaken
);

    localparam int RW = 2 * INDEX_LEN;

    logic [INDEX_LEN-1:0] spec_ghr;
    logic [INDEX_LEN-1:0] spec_ghr_nxt;
    logic [INDEX_LEN-1:0] commit_ghr;
    logic [INDEX_LEN-1:0] commit_ghr_nxt;
    logic [RW-1:0]        push_rec;
    logic [RW-1:0]        head_rec;
    logic [INDEX_LEN-1:0] head_index;
    logic [INDEX_LEN-1:0] head_hist;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_ok;
    logic                 recover;
    logic                 clear;
    logic                 push_ok;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^{IN_pc[31:INDEX_LEN+2], IN_pc[1:0]};

    assign OUT_readAddr = IN_pc[INDEX_LEN+1:2] ^ spec_ghr;
    assign OUT_stall    = fifo_full;

    // Record layout matches bhi_rec_t: index in the upper half, history below.
    assign push_rec   = {OUT_readAddr, spec_ghr};
    assign head_index = head_rec[RW-1:INDEX_LEN];
    assign head_hist  = head_rec[INDEX_LEN-1:0];

    // Flush beats mispredict recovery beats push; any clear cycle drops the push.
    assign pop_ok  = IN_resolveValid && !fifo_empty;
    assign recover = pop_ok && IN_mispredict;
    assign clear   = IN_flush || recover;
    assign push_ok = IN_pcValid && !fifo_full && !clear;

    BranchRecordFifo #(
        .W     (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .pop       (pop_ok),
        .clear     (clear),
        .push_data (push_rec),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_rec)
    );

    // Next history values; flush restores the commit history including this cycle's resolve.
    always_comb begin
        commit_ghr_nxt = commit_ghr;
        spec_ghr_nxt   = spec_ghr;
        if (pop_ok) commit_ghr_nxt = {commit_ghr[INDEX_LEN-2:0], IN_resolveTaken};
        if (IN_flush) begin
            spec_ghr_nxt = commit_ghr_nxt;
        end else if (recover) begin
            spec_ghr_nxt = {head_hist[INDEX_LEN-2:0], IN_resolveTaken};
        end else if (push_ok) begin
            spec_ghr_nxt = {spec_ghr[INDEX_LEN-2:0], IN_predTaken};
        end
    end

    // History registers and the registered table-update port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr       <= '0;
            commit_ghr     <= '0;
            OUT_writeEn    <= 1'b0;
            OUT_writeAddr  <= '0;
            OUT_writeTaken <= 1'b0;
        end else begin
            spec_ghr    <= spec_ghr_nxt;
            commit_ghr  <= commit_ghr_nxt;
            OUT_writeEn <= pop_ok;
            if (pop_ok) begin
                OUT_writeAddr  <= head_index;
                OUT_writeTaken <= IN_resolveTaken;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_indexer.sv
// Self-checking bench: queue-based reference model checked every cycle, plus
// hand-computed literal expectations for the key scenarios.
module tb_branch_history_indexer;
    import branch_history_indexer_pkg::*;

    localparam int IL    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          IN_pcValid;
    logic [31:0]   IN_pc;
    logic          IN_predTaken;
    logic [IL-1:0] OUT_readAddr;
    logic          OUT_stall;
    logic          IN_resolveValid;
    logic          IN_resolveTaken;
    logic          IN_mispredict;
    logic          IN_flush;
    logic          OUT_writeEn;
    logic [IL-1:0] OUT_writeAddr;
    logic          OUT_writeTaken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_history_indexer #(
        .INDEX_LEN  (IL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_pcValid      (IN_pcValid),
        .IN_pc           (IN_pc),
        .IN_predTaken    (IN_predTaken),
        .OUT_readAddr    (OUT_readAddr),
        .OUT_stall       (OUT_stall),
        .IN_resolveValid (IN_resolveValid),
        .IN_resolveTaken (IN_resolveTaken),
        .IN_mispredict   (IN_mispredict),
        .IN_flush        (IN_flush),
        .OUT_writeEn     (OUT_writeEn),
        .OUT_writeAddr   (OUT_writeAddr),
        .OUT_writeTaken  (OUT_writeTaken)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight branches as a queue, histories as plain values.
    bhi_rec_t      m_q[$];
    logic [IL-1:0] m_spec   = '0;
    logic [IL-1:0] m_commit = '0;
    logic          m_we     = 1'b0;
    logic [IL-1:0] m_wa     = '0;
    logic          m_wt     = 1'b0;

    always @(posedge clk or posedge rst) begin : model
        bhi_rec_t      h;
        bhi_rec_t      r;
        logic [IL-1:0] idx;
        bit            can_push;
        bit            popv;
        if (rst) begin
            m_q.delete();
            m_spec   = '0;
            m_commit = '0;
            m_we     = 1'b0;
            m_wa     = '0;
            m_wt     = 1'b0;
        end else begin
            idx      = IN_pc[IL+1:2] ^ m_spec;
            can_push = IN_pcValid && (m_q.size() < DEPTH);
            popv     = IN_resolveValid && (m_q.size() > 0);
            h        = '0;
            m_we     = popv;
            if (popv) begin
                h        = m_q.pop_front();
                m_wa     = h.index;
                m_wt     = IN_resolveTaken;
                m_commit = IL'((m_commit * 2) + IN_resolveTaken);
            end
            if (IN_flush) begin
                m_spec = m_commit;
                m_q.delete();
            end else if (popv && IN_mispredict) begin
                m_spec = IL'((h.hist * 2) + IN_resolveTaken);
                m_q.delete();
            end else if (can_push) begin
                r.index = idx;
                r.hist  = m_spec;
                m_q.push_back(r);
                m_spec = IL'((m_spec * 2) + IN_predTaken);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("readAddr", 32'(OUT_readAddr), 32'(IN_pc[IL+1:2] ^ m_spec));
            chk("stall", 32'(OUT_stall), 32'(m_q.size() == DEPTH));
            chk("writeEn", 32'(OUT_writeEn), 32'(m_we));
            if (m_we) begin
                chk("writeAddr", 32'(OUT_writeAddr), 32'(m_wa));
                chk("writeTaken", 32'(OUT_writeTaken), 32'(m_wt));
            end
        end
    end

    task automatic cyc(input bit pv, input logic [31:0] pc, input bit pt,
                       input bit rv, input bit rt, input bit mis, input bit fl);
        @(posedge clk);
        #1;
        IN_pcValid      = pv;
        IN_pc           = pc;
        IN_predTaken    = pt;
        IN_resolveValid = rv;
        IN_resolveTaken = rt;
        IN_mispredict   = mis;
        IN_flush        = fl;
    endtask

    task automatic idle(input logic [31:0] pc);
        cyc(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle(32'h100);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        IN_pcValid      = 1'b0;
        IN_pc           = 32'h100;
        IN_predTaken    = 1'b0;
        IN_resolveValid = 1'b0;
        IN_resolveTaken = 1'b0;
        IN_mispredict   = 1'b0;
        IN_flush        = 1'b0;
        rst             = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_writeEn", 32'(OUT_writeEn), 32'h0);
        chk("rst_writeAddr", 32'(OUT_writeAddr), 32'h0);
        chk("rst_stall", 32'(OUT_stall), 32'h0);
        chk("rst_readAddr", 32'(OUT_readAddr), 32'h40);
        @(posedge clk);
        #1 rst = 1'b0;

        // First index and speculative history update
        cyc(1, 32'h100, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("idx_first", 32'(OUT_readAddr), 32'h40);
        idle(32'h100);
        @(negedge clk);
        chk("idx_after_push", 32'(OUT_readAddr), 32'h41);

        // Correct resolve produces a table update one cycle later
        cyc(0, 32'h100, 0, 1, 1, 0, 0);
        idle(32'h100);
        @(negedge clk);
        chk("upd_en", 32'(OUT_writeEn), 32'h1);
        chk("upd_addr", 32'(OUT_writeAddr), 32'h40);
        chk("upd_taken", 32'(OUT_writeTaken), 32'h1);

        // Fill to capacity, stalled push ignored, pop-while-full blocks push
        for (int i = 0; i < 8; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0, 0);
        cyc(1, 32'h200, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_stall", 32'(OUT_stall), 32'h1);
        chk("full_idx", 32'(OUT_readAddr), 32'h80);
        cyc(1, 32'h200, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk("full_idx_held", 32'(OUT_readAddr), 32'h80);
        idle(32'h200);
        @(negedge clk);
        chk("unstall", 32'(OUT_stall), 32'h0);
        chk("unstall_upd_addr", 32'(OUT_writeAddr), 32'h01);
        cyc(1, 32'h300, 1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 32'h300, 0, 1, i[0], 0, 0);
        idle(32'h300);
        idle(32'h300);

        // Mispredict recovery
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 32'h100, 1, 0, 0, 0, 0);
        cyc(0, 32'h100, 0, 1, 0, 1, 0);
        @(negedge clk);
        chk("spec_07", 32'(OUT_readAddr), 32'h47);
        idle(32'h100);
        @(negedge clk);
        chk("mis_upd_en", 32'(OUT_writeEn), 32'h1);
        chk("mis_upd_addr", 32'(OUT_writeAddr), 32'h40);
        chk("mis_upd_taken", 32'(OUT_writeTaken), 32'h0);
        chk("mis_idx", 32'(OUT_readAddr), 32'h40);
        cyc(0, 32'h100, 0, 1, 0, 0, 0);
        idle(32'h100);
        @(negedge clk);
        chk("empty_resolve", 32'(OUT_writeEn), 32'h0);
        cyc(1, 32'h100, 1, 0, 0, 1, 0);
        idle(32'h100);
        @(negedge clk);
        chk("lone_mispredict", 32'(OUT_readAddr), 32'h41);

        // Flush restores committed history, drops same-cycle push
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 32'h100, 0, 0, 0, 0, 0);
        cyc(0, 32'h100, 0, 1, 1, 0, 0);
        cyc(0, 32'h100, 0, 1, 0, 0, 0);
        cyc(0, 32'h100, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h100, 1, 0, 0, 0, 0);
        cyc(1, 32'h100, 1, 0, 0, 0, 1);
        @(negedge clk);
        chk("pre_flush_idx", 32'(OUT_readAddr), 32'h4F);
        idle(32'h100);
        @(negedge clk);
        chk("flush_idx", 32'(OUT_readAddr), 32'h45);
        chk("flush_stall", 32'(OUT_stall), 32'h0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        cyc(0, 32'h100, 0, 1, 1, 0, 1);
        idle(32'h100);
        @(negedge clk);
        chk("flush_res_en", 32'(OUT_writeEn), 32'h1);
        chk("flush_res_addr", 32'(OUT_writeAddr), 32'h45);
        chk("flush_res_idx", 32'(OUT_readAddr), 32'h4B);
        cyc(0, 32'h100, 0, 1, 0, 0, 0);
        idle(32'h100);
        @(negedge clk);
        chk("flush_emptied", 32'(OUT_writeEn), 32'h0);

        // Asynchronous reset between edges with records in flight
        for (int i = 0; i < 3; i++) cyc(1, 32'h100, 1, 0, 0, 0, 0);
        cyc(0, 32'h100, 0, 1, 1, 0, 0);
        idle(32'h100);
        #1;
        chk("pre_rst_en", 32'(OUT_writeEn), 32'h1);
        chk("pre_rst_addr", 32'(OUT_writeAddr), 32'h4B);
        #1 rst = 1'b1;
        #1;
        chk("arst_en", 32'(OUT_writeEn), 32'h0);
        chk("arst_addr", 32'(OUT_writeAddr), 32'h0);
        chk("arst_taken", 32'(OUT_writeTaken), 32'h0);
        chk("arst_stall", 32'(OUT_stall), 32'h0);
        chk("arst_idx", 32'(OUT_readAddr), 32'h40);
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        idle(32'h100);
        idle(32'h100);
        @(negedge clk);
        chk("post_rst_en", 32'(OUT_writeEn), 32'h0);
        idle(32'h100);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
